// File: rtl/bf16_accel_dispatch.sv
// Issue/retire engine for the BF16 units: decodes ops, pulses one unit enable, captures each
// result at its fixed latency and retires results in issue order through a FWFT output FIFO.
module bf16_accel_dispatch #(
  parameter int DATA_W     = 32,
  parameter int FLAG_W     = 4,
  parameter int LAT_CONV   = 1,
  parameter int LAT_MINMAX = 1,
  parameter int LAT_FMA    = 3,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_operation,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  output logic [3:0]        unit_op,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic [DATA_W-1:0] unit_c,
  output logic              conv_en,
  output logic              maxmin_en,
  output logic              fma_en,
  input  logic [DATA_W-1:0] conv_result,
  input  logic [DATA_W-1:0] maxmin_result,
  input  logic [DATA_W-1:0] fma_result,
  input  logic [FLAG_W-1:0] conv_fpcsr,
  input  logic [FLAG_W-1:0] maxmin_fpcsr,
  input  logic [FLAG_W-1:0] fma_fpcsr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [FLAG_W-1:0] out_fpcsr,
  output logic              busy
);

  localparam int MAX_LAT_CM = (LAT_CONV > LAT_MINMAX) ? LAT_CONV : LAT_MINMAX;
  localparam int MAX_LAT    = (LAT_FMA > MAX_LAT_CM) ? LAT_FMA : MAX_LAT_CM;
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FLAG_W-1:0] ILL_FLAGS = FLAG_W'(4'b1000);

  typedef enum logic [1:0] {
    CLS_CONV   = 2'd0,
    CLS_MINMAX = 2'd1,
    CLS_FMA    = 2'd2,
    CLS_ILL    = 2'd3
  } cls_e;

  typedef struct packed {
    logic pend;
    cls_e cls;
  } slot_t;

  function automatic cls_e decode_op(input logic [3:0] op);
    if (op <= 4'd1)       return CLS_CONV;
    else if (op <= 4'd3)  return CLS_MINMAX;
    else if (op <= 4'd10) return CLS_FMA;
    else                  return CLS_ILL;
  endfunction

  function automatic int lat_of(input cls_e c);
    case (c)
      CLS_CONV:   return LAT_CONV;
      CLS_MINMAX: return LAT_MINMAX;
      CLS_FMA:    return LAT_FMA;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic                r_iss_vld;
  cls_e                r_iss_cls;
  logic [3:0]          r_unit_op;
  logic [DATA_W-1:0]   r_unit_a, r_unit_b, r_unit_c;
  logic                r_conv_en, r_maxmin_en, r_fma_en;
  slot_t [MAX_LAT-1:0] r_trk;
  logic [CNT_W-1:0]    r_inflight;
  logic [DATA_W-1:0]   r_mem_res [DEPTH];
  logic [FLAG_W-1:0]   r_mem_flg [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_fifo_cnt;

  cls_e                w_new_cls;
  int                  w_new_lat;
  int                  w_iss_lat;
  logic [MAX_LAT:0]    w_off_busy;
  slot_t [MAX_LAT-1:0] w_trk_sh;
  slot_t [MAX_LAT-1:0] w_trk_nxt;
  logic                w_order_stall, w_credit_ok, w_accept, w_push, w_pop;
  logic [DATA_W-1:0]   w_push_res;
  logic [FLAG_W-1:0]   w_push_flg;

  assign w_new_cls = decode_op(in_operation);
  assign w_trk_sh  = r_trk >> $bits(slot_t);

  // Index k of w_off_busy = an op that pushes k edges from now; the issue stage sits at its latency.
  always_comb begin
    w_new_lat     = lat_of(w_new_cls);
    w_iss_lat     = lat_of(r_iss_cls);
    w_off_busy    = '0;
    w_order_stall = 1'b0;
    w_trk_nxt     = w_trk_sh;
    for (int k = 0; k < MAX_LAT; k++) begin
      w_off_busy[k] = r_trk[k].pend;
      if (r_iss_vld && (k == w_iss_lat - 1)) w_trk_nxt[k] = '{pend: 1'b1, cls: r_iss_cls};
    end
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (r_iss_vld && (k == w_iss_lat)) w_off_busy[k] = 1'b1;
    end
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (w_off_busy[k] && (k > w_new_lat)) w_order_stall = 1'b1;
    end
  end

  always_comb begin
    w_push_res = '0;
    w_push_flg = ILL_FLAGS;
    case (r_trk[0].cls)
      CLS_CONV:   begin w_push_res = conv_result;   w_push_flg = conv_fpcsr;   end
      CLS_MINMAX: begin w_push_res = maxmin_result; w_push_flg = maxmin_fpcsr; end
      CLS_FMA:    begin w_push_res = fma_result;    w_push_flg = fma_fpcsr;    end
      default:    begin w_push_res = '0;            w_push_flg = ILL_FLAGS;    end
    endcase
  end

  assign w_credit_ok = ({1'b0, r_fifo_cnt} + {1'b0, r_inflight}) < (CNT_W + 1)'(DEPTH);
  assign in_ready    = !reset && w_credit_ok && !w_order_stall;
  assign w_accept    = in_valid && in_ready;
  assign w_push      = r_trk[0].pend;
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_vld   <= 1'b0;
      r_iss_cls   <= CLS_CONV;
      r_unit_op   <= '0;
      r_unit_a    <= '0;
      r_unit_b    <= '0;
      r_unit_c    <= '0;
      r_conv_en   <= 1'b0;
      r_maxmin_en <= 1'b0;
      r_fma_en    <= 1'b0;
      r_trk       <= '0;
      r_inflight  <= '0;
    end else begin
      r_iss_vld   <= w_accept;
      r_iss_cls   <= w_new_cls;
      r_conv_en   <= w_accept && (w_new_cls == CLS_CONV);
      r_maxmin_en <= w_accept && (w_new_cls == CLS_MINMAX);
      r_fma_en    <= w_accept && (w_new_cls == CLS_FMA);
      if (w_accept) begin
        r_unit_op <= in_operation;
        r_unit_a  <= in_a;
        r_unit_b  <= in_b;
        r_unit_c  <= in_c;
      end
      r_trk      <= w_trk_nxt;
      r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_push);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem_res[r_wr_ptr] <= w_push_res;
      r_mem_flg[r_wr_ptr] <= w_push_flg;
    end
  end

  assign unit_op    = r_unit_op;
  assign unit_a     = r_unit_a;
  assign unit_b     = r_unit_b;
  assign unit_c     = r_unit_c;
  assign conv_en    = r_conv_en;
  assign maxmin_en  = r_maxmin_en;
  assign fma_en     = r_fma_en;
  assign out_valid  = (r_fifo_cnt != '0);
  assign out_result = out_valid ? r_mem_res[r_rd_ptr] : '0;
  assign out_fpcsr  = out_valid ? r_mem_flg[r_rd_ptr] : '0;
  assign busy       = (r_inflight != '0) || out_valid;

endmodule

// File: tb/tb_bf16_accel_dispatch.sv
// Bench for bf16_accel_dispatch: behavioural unit models, in-order scoreboard, directed and random ops.
module tb_bf16_accel_dispatch;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;
  localparam int LAT_CONV = 1;
  localparam int LAT_MINMAX = 1;
  localparam int LAT_FMA = 3;
  localparam int DEPTH = 4;

  logic clk, reset, in_valid, in_ready;
  logic [3:0] in_operation, unit_op;
  logic [31:0] in_a, in_b, in_c, unit_a, unit_b, unit_c;
  logic conv_en, maxmin_en, fma_en;
  logic [31:0] conv_result, maxmin_result, fma_result, out_result;
  logic [3:0] conv_fpcsr, maxmin_fpcsr, fma_fpcsr, out_fpcsr;
  logic out_valid, out_ready, busy;

  bf16_accel_dispatch #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .LAT_CONV(LAT_CONV), .LAT_MINMAX(LAT_MINMAX),
    .LAT_FMA(LAT_FMA), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_operation(in_operation), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
    .conv_en(conv_en), .maxmin_en(maxmin_en), .fma_en(fma_en),
    .conv_result(conv_result), .maxmin_result(maxmin_result), .fma_result(fma_result),
    .conv_fpcsr(conv_fpcsr), .maxmin_fpcsr(maxmin_fpcsr), .fma_fpcsr(fma_fpcsr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_fpcsr(out_fpcsr), .busy(busy)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;
  typedef struct {
    int          cyc;
    int          cls;
    logic [3:0]  op;
    logic [31:0] a, b, c;
  } iss_t;
  typedef struct {
    int          due;
    logic [31:0] r;
    logic [3:0]  f;
  } ures_t;

  exp_t  sb[$];
  iss_t  iss_q[$];
  ures_t conv_q[$], mm_q[$], fma_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ordy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic int cls_of(input logic [3:0] op);
    if (op < 4'd2) return 0;
    if (op < 4'd4) return 1;
    if (op < 4'd11) return 2;
    return 3;
  endfunction

  // What each unit computes; illegal ops retire as zero with the invalid flag.
  function automatic void unit_fn(input int cls, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] c,
                                  output logic [31:0] r, output logic [3:0] f);
    case (cls)
      0: begin r = a ^ {b[15:0], b[31:16]}; f = a[3:0] ^ op; end
      1: begin r = (a > b) ? a : b; f = b[3:0]; end
      2: begin r = a + b * c; f = c[3:0] ^ op; end
      default: begin r = 32'd0; f = 4'b1000; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  // Unit models: check the issue pulse each cycle, then present results exactly LAT cycles later.
  initial begin
    logic [2:0] exp_en;
    logic [31:0] r;
    logic [3:0] f;
    iss_t ie;
    ures_t u;
    conv_result = 0; maxmin_result = 0; fma_result = 0;
    conv_fpcsr = 0; maxmin_fpcsr = 0; fma_fpcsr = 0;
    forever begin
      @(negedge clk);
      exp_en = 3'b000;
      if (iss_q.size() != 0 && iss_q[0].cyc == cyc) begin
        ie = iss_q.pop_front();
        case (ie.cls)
          0: exp_en = 3'b001;
          1: exp_en = 3'b010;
          2: exp_en = 3'b100;
          default: exp_en = 3'b000;
        endcase
        chk("unit_op", 64'(unit_op), 64'(ie.op));
        chk("unit_abc", {32'd0, unit_a ^ unit_b ^ unit_c}, {32'd0, ie.a ^ ie.b ^ ie.c});
        chk("unit_a", 64'(unit_a), 64'(ie.a));
      end
      chk("enables", 64'({fma_en, maxmin_en, conv_en}), 64'(exp_en));
      if (conv_en) begin
        unit_fn(0, unit_op, unit_a, unit_b, unit_c, r, f);
        conv_q.push_back('{due: cyc + LAT_CONV, r: r, f: f});
      end
      if (maxmin_en) begin
        unit_fn(1, unit_op, unit_a, unit_b, unit_c, r, f);
        mm_q.push_back('{due: cyc + LAT_MINMAX, r: r, f: f});
      end
      if (fma_en) begin
        unit_fn(2, unit_op, unit_a, unit_b, unit_c, r, f);
        fma_q.push_back('{due: cyc + LAT_FMA, r: r, f: f});
      end
      if (conv_q.size() != 0 && conv_q[0].due == cyc) begin
        u = conv_q.pop_front(); conv_result = u.r; conv_fpcsr = u.f;
      end else begin
        conv_result = $urandom; conv_fpcsr = 4'($urandom);
      end
      if (mm_q.size() != 0 && mm_q[0].due == cyc) begin
        u = mm_q.pop_front(); maxmin_result = u.r; maxmin_fpcsr = u.f;
      end else begin
        maxmin_result = $urandom; maxmin_fpcsr = 4'($urandom);
      end
      if (fma_q.size() != 0 && fma_q[0].due == cyc) begin
        u = fma_q.pop_front(); fma_result = u.r; fma_fpcsr = u.f;
      end else begin
        fma_result = $urandom; fma_fpcsr = 4'($urandom);
      end
    end
  end

  // Output monitor: owns out_ready, compares the FIFO head against the scoreboard.
  initial begin
    logic rdy;
    exp_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      rdy = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      out_ready = rdy;
      if (!reset) begin
        chkb("busy", busy, sb.size() != 0);
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out @cycle %0d: got out_valid=1 result %h required no output",
                     cyc, out_result);
          end else begin
            e = sb[0];
            chk("out_result", 64'(out_result), 64'(e.r));
            chk("out_fpcsr", 64'(out_fpcsr), 64'(e.f));
            if (rdy) void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Holds the request until accepted or max_wait cycles pass; returns at 1ns after the next negedge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input int max_wait, output bit acc, output int acc_cyc);
    logic [31:0] r;
    logic [3:0] f;
    in_valid = 1'b1; in_operation = op; in_a = a; in_b = b; in_c = c;
    acc = 1'b0;
    acc_cyc = -1;
    for (int w = 0; w <= max_wait && !acc; w++) begin
      #2;
      if (in_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        unit_fn(cls_of(op), op, a, b, c, r, f);
        sb.push_back('{r: r, f: f});
        iss_q.push_back('{cyc: cyc + 1, cls: cls_of(op), op: op, a: a, b: b, c: c});
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    ordy_mode = 0;
    while ((sb.size() != 0 || busy) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    chkb("drain_busy", busy, 1'b0);
  endtask

  initial begin
    bit acc;
    int t0, t1;
    int acc_c[6];
    reset = 1'b1; in_valid = 1'b0; in_operation = 4'd0; in_a = 0; in_b = 0; in_c = 0;
    step(); step();
    chkb("rst_in_ready", in_ready, 1'b0);
    chk("rst_en", 64'({conv_en, maxmin_en, fma_en}), 64'd0);
    chk("rst_unit", {28'd0, unit_op, unit_a}, 64'd0);
    chk("rst_unit_bc", {unit_b, unit_c}, 64'd0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", {28'd0, out_fpcsr, out_result}, 64'd0);
    chkb("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    chkb("idle_in_ready", in_ready, 1'b1);
    step();

    // Single FMA: enable in the next cycle, out_valid exactly 5 cycles after accept.
    send(4'b0100, 32'h3F80_0000, 32'd1, 32'h0080_0000, 0, acc, t0);
    chkb("t1_acc", acc, 1'b1);
    wait_until(t0 + 4);
    chkb("t1_early_valid", out_valid, 1'b0);
    wait_until(t0 + 5);
    chkb("t1_valid", out_valid, 1'b1);
    chk("t1_result", 64'(out_result), 64'h4000_0000);
    drain(50);

    // FMA then CONV: CONV must wait until it can retire after the FMA.
    send(4'b0100, 32'h1234_5678, 32'h3, 32'h5, 0, acc, t0);
    chkb("t2_fma_acc", acc, 1'b1);
    send(4'b0000, 32'hA5A5_0F0F, 32'h0102_0304, 32'h0, 10, acc, t1);
    chkb("t2_conv_acc", acc, 1'b1);
    chk("t2_conv_cycle", 64'(t1 - t0), 64'd3);
    wait_until(t0 + 4);
    chkb("t2_v4", out_valid, 1'b0);
    wait_until(t0 + 5);
    chkb("t2_v5", out_valid, 1'b1);
    wait_until(t0 + 6);
    chkb("t2_v6", out_valid, 1'b1);
    drain(50);

    // Credit limit: with out_ready low only DEPTH ops are accepted, back-to-back.
    ordy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      send(4'b0001, $urandom, $urandom, $urandom, 5, acc, acc_c[i]);
      chkb("t3_acc", acc, 1'b1);
      chk("t3_b2b", 64'(acc_c[i] - acc_c[0]), 64'(i));
    end
    send(4'b0000, $urandom, $urandom, $urandom, 12, acc, t0);
    chkb("t3_fifth_blocked", acc, 1'b0);
    in_operation = 4'b0000;
    #1;
    chkb("t3_in_ready", in_ready, 1'b0);
    ordy_mode = 0;
    for (int i = 4; i < 6; i++) begin
      send(4'b0000, $urandom, $urandom, $urandom, 20, acc, acc_c[i]);
      chkb("t3_late_acc", acc, 1'b1);
    end
    drain(50);

    // Illegal opcode: no enable (checked by the unit model), result 0 with flag 4'b1000.
    send(4'b1100, 32'hFFFF_FFFF, 32'h1, 32'h2, 0, acc, t0);
    chkb("t4_acc", acc, 1'b1);
    drain(50);

    // Reset with FMA in flight: nothing from that op may ever retire.
    send(4'b0101, 32'h7, 32'h8, 32'h9, 0, acc, t0);
    chkb("t5_acc", acc, 1'b1);
    wait_until(t0 + 2);
    reset = 1'b1;
    sb.delete();
    iss_q.delete();
    wait_until(t0 + 3);
    chkb("t5_out_valid", out_valid, 1'b0);
    chkb("t5_busy", busy, 1'b0);
    chkb("t5_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    wait_until(t0 + 5);
    chkb("t5_no_capture", out_valid, 1'b0);
    wait_until(t0 + 8);
    drain(50);

    // Mixed stream retires MINMAX, FMA, CONV in issue order.
    send(4'b0010, 32'h4000_0000, 32'h3000_0000, 32'h0, 10, acc, t0);
    chkb("t6_acc_mm", acc, 1'b1);
    send(4'b0111, 32'h10, 32'h20, 32'h30, 10, acc, t0);
    chkb("t6_acc_fma", acc, 1'b1);
    send(4'b0001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 10, acc, t0);
    chkb("t6_acc_conv", acc, 1'b1);
    drain(50);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      if (i % 40 == 0) ordy_mode = (i % 80 == 0) ? 2 : 0;
      send(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 60, acc, t0);
      chkb("rnd_acc", acc, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
